// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-enable synchronous write and combinational read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated data-memory slave with valid/ready request and response channels.
// Optional load/store counters are built when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_err;
    logic              acc_go;
    logic [WORD_W-1:0] arr_rdata;
    logic [WORD_W-1:0] rsp_data_nxt;

    // With zero wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    assign acc_err = (acc_addr[1:0] != 2'b00) ||
                     (32'(acc_addr[31:2]) >= 32'(DEPTH_WORDS));

    assign acc_go = ((state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state == WAIT) && (cnt == 4'd1));

    assign rsp_data_nxt = (acc_we || acc_err) ? '0 : arr_rdata;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (acc_go && acc_we && !acc_err),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (arr_rdata)
    );

    // Request latch: data path only, loaded on accept.
    always_ff @(posedge clk) begin
        if ((state == IDLE) && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_data_nxt;
                            rsp_err   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_data_nxt;
                        rsp_err   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if ((state == RESP) && rsp_ready && !rsp_err) begin
            if (we_q) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance with two wait states
    logic        req_valid = 0, req_we = 0, rsp_ready = 0;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_be = 0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    // Instance with zero wait states
    logic        z_req_valid = 0, z_req_we = 0, z_rsp_ready = 0;
    logic [31:0] z_req_addr = 0, z_req_wdata = 0;
    logic [3:0]  z_req_be = 0;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count, wr_count, z_rd_count, z_wr_count;
`endif

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst_n(rst_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
`ifdef DMEM_STATS_EN
        , .rd_count(z_rd_count), .wr_count(z_wr_count)
`endif
    );

    // One transaction on the wait-stated instance; lat counts cycles from the accept cycle.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic zxact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] rdata, output logic err,
                         output int lat);
        int n;
        n = 0;
        while (!z_req_ready && n < 50) begin @(posedge clk); #1; n++; end
        z_req_valid = 1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata; z_req_be = be;
        @(posedge clk); #1;
        z_req_valid = 0;
        lat = 1;
        while (!z_rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        rdata = z_rsp_rdata;
        err   = z_rsp_err;
        z_rsp_ready = 1;
        @(posedge clk); #1;
        z_rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready/valid/err=%b rdata=%h, required 100 / 00000000",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
        n_tests++;
        if ({z_req_ready, z_rsp_valid, z_rsp_err} !== 3'b100 || z_rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state_z: ready/valid/err=%b rdata=%h, required 100 / 00000000",
                     {z_req_ready, z_rsp_valid, z_rsp_err}, z_rsp_rdata);
        end
        #3 rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, rd, er, lat);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL store_full: rdata=%h err=%b lat=%0d, required 00000000 0 3", rd, er, lat);
        end
        xact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
            n_fail++;
            $display("FAIL load_full: rdata=%h err=%b lat=%0d, required deadbeef 0 3", rd, er, lat);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h4, 32'h0000_5500, 4'b0010, rd, er, lat);
        xact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_merge: rdata=%h err=%b, required dead55ef 0", rd, er);
        end
        xact(1'b1, 32'h4, 32'hFFFF_FFFF, 4'b0000, rd, er, lat);
        n_tests++;
        if (er !== 1'b0) begin
            n_fail++;
            $display("FAIL be_zero_err: err=%b, required 0", er);
        end
        xact(1'b0, 32'h4, 32'h0, 4'hF, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD55EF) begin
            n_fail++;
            $display("FAIL be_zero_data: rdata=%h, required dead55ef", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        xact(1'b1, 32'h0, 32'hA5A5_0000, 4'hF, rd, er, lat);
        xact(1'b0, 32'h2, 32'h0, 4'hF, rd, er, lat);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_load: rdata=%h err=%b, required 00000000 1", rd, er);
        end
        xact(1'b0, 32'h400, 32'h0, 4'hF, rd, er, lat);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL range_load: rdata=%h err=%b, required 00000000 1", rd, er);
        end
        xact(1'b1, 32'h2, 32'h1111_1111, 4'hF, rd, er, lat);
        n_tests++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL misaligned_store: err=%b, required 1", er);
        end
        xact(1'b1, 32'h400, 32'h2222_2222, 4'hF, rd, er, lat);
        n_tests++;
        if (er !== 1'b1) begin
            n_fail++;
            $display("FAIL range_store: err=%b, required 1", er);
        end
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hA5A5_0000 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL word0_intact: rdata=%h err=%b, required a5a50000 0", rd, er);
        end
        xact(1'b1, 32'h3FC, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        xact(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin
            n_fail++;
            $display("FAIL last_word: rdata=%h err=%b, required 0badf00d 0", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n; int bad;
        req_valid = 1; req_we = 0; req_addr = 32'h4; req_be = 4'h0;
        @(posedge clk); #1;
        req_addr = 32'h0;  // keep a second request pending during the stall
        n = 0;
        while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!rsp_valid || rsp_rdata !== 32'hDEAD55EF || rsp_err !== 1'b0 || req_ready)
                bad++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: %0d bad cycles (valid=%b rdata=%h ready=%b), required 0",
                     bad, rsp_valid, rsp_rdata, req_ready);
        end
        req_valid = 0;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b ready=%b, required 0 1", rsp_valid, req_ready);
        end
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hA5A5_0000 || lat != 3) begin
            n_fail++;
            $display("FAIL after_stall: rdata=%h lat=%0d, required a5a50000 3", rd, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        req_valid = 1; req_we = 1; req_addr = 32'h4; req_wdata = 32'h1234_5678; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: ready/valid/err=%b rdata=%h, required 100 / 00000000",
                     {req_ready, rsp_valid, rsp_err}, rsp_rdata);
        end
        #5 rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        xact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_commit: rdata=%h err=%b, required dead55ef 0", rd, er);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd; logic er; int lat;
        zxact(1'b1, 32'h8, 32'h1122_3344, 4'hF, rd, er, lat);
        n_tests++;
        if (lat != 1 || er !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL zw_store: lat=%0d err=%b rdata=%h, required 1 0 00000000", lat, er, rd);
        end
        zxact(1'b0, 32'h8, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (lat != 1 || rd !== 32'h1122_3344 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL zw_load: lat=%0d rdata=%h err=%b, required 1 11223344 0", lat, rd, er);
        end
        zxact(1'b0, 32'h1, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd !== 32'h0 || er !== 1'b1) begin
            n_fail++;
            $display("FAIL zw_err: rdata=%h err=%b, required 00000000 1", rd, er);
        end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic er; int lat;
        rst_n = 0;
        #7 rst_n = 1;
        @(posedge clk); #1;
        n_tests++;
        if (rd_count !== 16'd0 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL stats_reset: rd=%0d wr=%0d, required 0 0", rd_count, wr_count);
        end
        xact(1'b0, 32'h4, 32'h0, 4'h0, rd, er, lat);
        xact(1'b1, 32'hC, 32'h5, 4'hF, rd, er, lat);
        xact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        xact(1'b0, 32'h2, 32'h0, 4'h0, rd, er, lat);
        xact(1'b1, 32'h10, 32'h6, 4'hF, rd, er, lat);
        xact(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (rd_count !== 16'd3 || wr_count !== 16'd2) begin
            n_fail++;
            $display("FAIL stats_counts: rd=%0d wr=%0d, required 3 2", rd_count, wr_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_zero_wait();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
